adma_as_atx_complete: RTL and testbench

- Completion tracker for the AXI-side DMA engine. It sits on the write-response end of the transaction generator.
- The generator announces each issued AXI burst with atx_start and atx_start_last. This block queues those announcements and consumes the AXI B channel.
- It reports one completion, with an error status, per DMA transaction once the B response of that transaction's last burst has been accepted.

---
 rtl/adma_as_atx_complete.sv | 112 +++++++++++
 tb/tb_adma_as_atx_complete.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/adma_as_atx_complete.sv
// Completion tracker for the AXI-side DMA write path: queues per-burst "last" flags,
// consumes B responses in order and reports one completion per DMA transaction.
module adma_as_atx_complete #(
    parameter int MST_ID_W  = 5,
    parameter int OUTST_NUM = 4,
    localparam int OUTST_W  = $clog2(OUTST_NUM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                atx_start,
    input  logic                atx_start_last,
    output logic                atx_issue_rdy,
    input  logic [MST_ID_W-1:0] atx_id,
    input  logic [MST_ID_W-1:0] bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic                tx_done_vld,
    output logic                tx_done_err,
    input  logic                tx_done_rdy,
    output logic [OUTST_W:0]    outst_cnt,
    output logic                idle
);

    localparam logic [OUTST_W:0] FULL_CNT = (OUTST_W+1)'(OUTST_NUM);
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
    localparam logic [1:0]       RESP_DECERR = 2'b11;

    logic [OUTST_NUM-1:0] flag_reg;
    logic [OUTST_NUM-1:0] wr_sel;
    logic [OUTST_W-1:0]   wr_ptr_reg;
    logic [OUTST_W-1:0]   rd_ptr_reg;
    logic [OUTST_W:0]     cnt_reg;
    logic                 err_acc_reg;
    logic                 done_vld_reg;
    logic                 done_err_reg;

    logic push;
    logic pop;
    logic head_last;
    logic beat_err;

    always_comb begin
        atx_issue_rdy = (cnt_reg != FULL_CNT);
        // A completion waiting for acceptance blocks further B beats.
        bready        = (cnt_reg != '0) & ~(done_vld_reg & ~tx_done_rdy);
        push          = atx_start & atx_issue_rdy;
        pop           = bvalid & bready;
        head_last     = flag_reg[rd_ptr_reg];
        beat_err      = (bresp == RESP_SLVERR) | (bresp == RESP_DECERR) | (bid != atx_id);
    end

    generate
        for (genvar gi = 0; gi < OUTST_NUM; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push & (wr_ptr_reg == OUTST_W'(gi));
        end
    endgenerate

    // Flag storage carries no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < OUTST_NUM; i++) begin
            if (wr_sel[i]) begin
                flag_reg[i] <= atx_start_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
            err_acc_reg  <= 1'b0;
            done_vld_reg <= 1'b0;
            done_err_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + OUTST_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + OUTST_W'(1);
            end

            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + (OUTST_W+1)'(1);
                2'b01:   cnt_reg <= cnt_reg - (OUTST_W+1)'(1);
                default: cnt_reg <= cnt_reg;
            endcase

            // A new last-beat pop wins over clearing the accepted completion.
            if (pop && head_last) begin
                done_vld_reg <= 1'b1;
                done_err_reg <= err_acc_reg | beat_err;
                err_acc_reg  <= 1'b0;
            end else begin
                if (pop) begin
                    err_acc_reg <= err_acc_reg | beat_err;
                end
                if (done_vld_reg && tx_done_rdy) begin
                    done_vld_reg <= 1'b0;
                    done_err_reg <= 1'b0;
                end
            end
        end
    end

    assign tx_done_vld = done_vld_reg;
    assign tx_done_err = done_err_reg;
    assign outst_cnt   = cnt_reg;
    assign idle        = (cnt_reg == '0) & ~done_vld_reg;

endmodule

// File: tb/tb_adma_as_atx_complete.sv
// Bench for adma_as_atx_complete: cycle-level reference model plus a completion scoreboard.
module tb_adma_as_atx_complete;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       atx_start = 1'b0;
    logic       atx_start_last = 1'b0;
    logic       atx_issue_rdy;
    logic [4:0] atx_id = 5'h03;
    logic [4:0] bid = 5'h00;
    logic [1:0] bresp = 2'b00;
    logic       bvalid = 1'b0;
    logic       bready;
    logic       tx_done_vld;
    logic       tx_done_err;
    logic       tx_done_rdy = 1'b1;
    logic [2:0] outst_cnt;
    logic       idle;

    adma_as_atx_complete #(.MST_ID_W(5), .OUTST_NUM(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .atx_start(atx_start), .atx_start_last(atx_start_last), .atx_issue_rdy(atx_issue_rdy),
        .atx_id(atx_id), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .tx_done_vld(tx_done_vld), .tx_done_err(tx_done_err), .tx_done_rdy(tx_done_rdy),
        .outst_cnt(outst_cnt), .idle(idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit sb[$];     // expected tx_done_err per completion
    bit mq[$];     // model of the last-flag queue
    int m_cnt = 0;
    bit m_acc = 1'b0;
    bit m_vld = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus: drive, check handshake readies, advance model and DUT, check state.
    task automatic cyc(input bit st, input bit lst, input bit bv, input logic [4:0] id, input logic [1:0] rsp);
        bit push_e, pop_e, f, e, nvld;
        atx_start = st; atx_start_last = lst; bvalid = bv; bid = id; bresp = rsp;
        #1;
        chk("issue_rdy", atx_issue_rdy, int'(m_cnt != N));
        chk("bready", bready, int'((m_cnt != 0) && !(m_vld && !tx_done_rdy)));
        push_e = st && (m_cnt != N);
        pop_e  = bv && (m_cnt != 0) && !(m_vld && !tx_done_rdy);
        nvld   = m_vld && !tx_done_rdy;
        if (pop_e) begin
            f = mq.pop_front();
            e = rsp[1] || (id != atx_id);
            if (f) begin
                sb.push_back(m_acc | e);
                m_acc = 1'b0;
                nvld = 1'b1;
            end else begin
                m_acc = m_acc | e;
            end
        end
        if (push_e) mq.push_back(lst);
        m_cnt = m_cnt + int'(push_e) - int'(pop_e);
        m_vld = nvld;
        @(posedge clk);
        #1;
        atx_start = 1'b0; bvalid = 1'b0;
        chk("outst_cnt", outst_cnt, m_cnt);
        chk("done_vld", tx_done_vld, int'(m_vld));
        chk("idle", idle, int'((m_cnt == 0) && !m_vld));
    endtask

    // Completion monitor: one line per accepted completion.
    always @(negedge clk) begin
        if (rst_n && tx_done_vld && tx_done_rdy) begin
            if (sb.size() == 0) begin
                chk("unexp_done", 1, 0);
            end else begin
                automatic bit exp_err = sb.pop_front();
                $display("completion t=%0t err=%0d exp=%0d", $time, tx_done_err, exp_err);
                chk("done_err", tx_done_err, int'(exp_err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_cnt", outst_cnt, 0);
        chk("rst_vld", tx_done_vld, 0);
        chk("rst_err", tx_done_err, 0);
        chk("rst_bready", bready, 0);
        chk("rst_issue", atx_issue_rdy, 1);
        chk("rst_idle", idle, 1);

        // Single burst, OKAY
        cyc(1, 1, 0, 5'h03, 2'b00);
        cyc(0, 0, 1, 5'h03, 2'b00);
        chk("t1_lat_vld", tx_done_vld, 1);
        chk("t1_err", tx_done_err, 0);
        cyc(0, 0, 0, 5'h03, 2'b00);
        chk("t1_idle", idle, 1);

        // Three bursts with a middle SLVERR, then a clean EXOKAY transaction
        cyc(1, 0, 0, 5'h03, 2'b00);
        cyc(1, 0, 0, 5'h03, 2'b00);
        cyc(1, 1, 0, 5'h03, 2'b00);
        cyc(0, 0, 1, 5'h03, 2'b00);
        chk("t2_no_done1", tx_done_vld, 0);
        cyc(0, 0, 1, 5'h03, 2'b10);
        chk("t2_no_done2", tx_done_vld, 0);
        cyc(0, 0, 1, 5'h03, 2'b00);
        chk("t2_err", tx_done_err, 1);
        cyc(1, 1, 0, 5'h03, 2'b00);
        cyc(0, 0, 1, 5'h03, 2'b01);
        chk("t2_next_err", tx_done_err, 0);
        cyc(0, 0, 0, 5'h03, 2'b00);

        // Full queue, ignored push, pop without bypass, push+pop
        cyc(1, 0, 0, 5'h03, 2'b00);
        cyc(1, 0, 0, 5'h03, 2'b00);
        cyc(1, 0, 0, 5'h03, 2'b00);
        cyc(1, 1, 0, 5'h03, 2'b00);
        chk("t3_full_rdy", atx_issue_rdy, 0);
        chk("t3_full_cnt", outst_cnt, 4);
        cyc(1, 1, 0, 5'h03, 2'b00);
        chk("t3_ignored", outst_cnt, 4);
        cyc(1, 0, 1, 5'h03, 2'b00);
        chk("t3_no_bypass", outst_cnt, 3);
        cyc(1, 0, 1, 5'h03, 2'b00);
        chk("t3_push_pop", outst_cnt, 3);
        cyc(1, 1, 0, 5'h03, 2'b00);
        chk("t3_refull_cnt", outst_cnt, 4);
        chk("t3_refull_rdy", atx_issue_rdy, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 5'h03, 2'b00);
        cyc(0, 0, 0, 5'h03, 2'b00);

        // Completion backpressure
        tx_done_rdy = 1'b0;
        cyc(1, 1, 0, 5'h03, 2'b00);
        cyc(1, 1, 0, 5'h03, 2'b00);
        cyc(0, 0, 1, 5'h03, 2'b00);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 1, 5'h03, 2'b10);
            chk("t4_stall", bready, 0);
        end
        tx_done_rdy = 1'b1;
        cyc(0, 0, 1, 5'h03, 2'b10);
        chk("t4_second_vld", tx_done_vld, 1);
        chk("t4_second_err", tx_done_err, 1);
        cyc(0, 0, 0, 5'h03, 2'b00);

        // ID mismatch on a last beat, then bvalid with an empty queue
        cyc(1, 1, 0, 5'h03, 2'b00);
        cyc(0, 0, 1, 5'h07, 2'b00);
        chk("t5_id_err", tx_done_err, 1);
        cyc(0, 0, 0, 5'h03, 2'b00);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 5'h03, 2'b00);
        chk("t5_empty_cnt", outst_cnt, 0);

        // Reset mid-operation
        tx_done_rdy = 1'b0;
        cyc(1, 1, 0, 5'h03, 2'b00);
        cyc(1, 0, 0, 5'h03, 2'b00);
        cyc(1, 1, 0, 5'h03, 2'b00);
        cyc(0, 0, 1, 5'h03, 2'b00);
        chk("t6_pre_cnt", outst_cnt, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        sb.delete(); mq.delete();
        m_cnt = 0; m_acc = 1'b0; m_vld = 1'b0;
        chk("t6_cnt", outst_cnt, 0);
        chk("t6_vld", tx_done_vld, 0);
        chk("t6_bready", bready, 0);
        chk("t6_issue", atx_issue_rdy, 1);
        tx_done_rdy = 1'b1;
        cyc(1, 1, 0, 5'h03, 2'b00);
        cyc(0, 0, 1, 5'h03, 2'b00);
        cyc(0, 0, 0, 5'h03, 2'b00);

        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
